// File: rtl/wb_disp_sched_pkg.sv
// wb_disp_sched_pkg: shared types and constants for the writeback display scheduler.
// Contents: FSM state encoding, FIFO entry struct, BCD geometry, and the
// single add-3/shift step used by the sequential binary-to-BCD converter.
package wb_disp_pkg;
    localparam int DIGIT_W = 4;
    localparam int DIGITS  = 10;
    localparam int BCD_W   = DIGIT_W * DIGITS;
    localparam int ITERS   = 32;

    typedef enum logic [1:0] {IDLE, CONV, DONE, SHOW} state_t;

    typedef struct packed {
        logic [7:0]  pc;
        logic [4:0]  rd;
        logic [31:0] val;
    } entry_t;

    // One double-dabble iteration: correct every digit >= 5, then shift in b.
    function automatic logic [BCD_W-1:0] bcd_step(input logic [BCD_W-1:0] acc, input logic b);
        logic [BCD_W-1:0] a;
        a = acc;
        for (int i = 0; i < DIGITS; i++)
            if (a[i*DIGIT_W +: DIGIT_W] >= 4'd5)
                a[i*DIGIT_W +: DIGIT_W] = a[i*DIGIT_W +: DIGIT_W] + 4'd3;
        return {a[BCD_W-2:0], b};
    endfunction
endpackage

// File: rtl/wb_disp_sched_if.sv
// wb_disp_sched_if: writeback capture and display bus of the scheduler.
// Ports (signals): wb_valid/wb_pc/wb_rd/wb_val writeback strobe and payload,
// step_req manual advance, disp_* converted entry, fifo_full, drop_cnt.
// Modports: master drives writebacks and observes the display, slave is the scheduler.
interface wb_disp_sched_if
    import wb_disp_pkg::*;
#(
    parameter int DROP_W = 8
) ();
    logic               wb_valid;
    logic [7:0]         wb_pc;
    logic [4:0]         wb_rd;
    logic [31:0]        wb_val;
    logic               step_req;
    logic               disp_valid;
    logic [7:0]         disp_pc;
    logic [4:0]         disp_rd;
    logic               disp_neg;
    logic [DIGIT_W-1:0] disp_hund;
    logic [DIGIT_W-1:0] disp_ten;
    logic [DIGIT_W-1:0] disp_one;
    logic               disp_ovf;
    logic               fifo_full;
    logic [DROP_W-1:0]  drop_cnt;

    modport master (
        output wb_valid, wb_pc, wb_rd, wb_val, step_req,
        input  disp_valid, disp_pc, disp_rd, disp_neg, disp_hund, disp_ten, disp_one,
               disp_ovf, fifo_full, drop_cnt
    );

    modport slave (
        input  wb_valid, wb_pc, wb_rd, wb_val, step_req,
        output disp_valid, disp_pc, disp_rd, disp_neg, disp_hund, disp_ten, disp_one,
               disp_ovf, fifo_full, drop_cnt
    );
endinterface

// File: rtl/wb_disp_sched_bin2bcd_seq.sv
// bin2bcd_seq: sequential 32-bit binary to 10-digit BCD converter (shift-add-3).
// Ports: clk, rst (async active-low), start loads din, busy while iterating,
// done 1-cycle pulse once bcd holds the final result, bcd 40-bit result.
// The start edge already performs the first iteration, so the result is ready
// ITERS edges after start.
module bin2bcd_seq
    import wb_disp_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      din,
    output logic             busy,
    output logic             done,
    output logic [BCD_W-1:0] bcd
);
    logic [31:0] sr;
    logic [5:0]  cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr   <= '0;
            cnt  <= '0;
            bcd  <= '0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                bcd  <= {{(BCD_W-1){1'b0}}, din[31]};
                sr   <= {din[30:0], 1'b0};
                cnt  <= 6'(ITERS - 1);
                busy <= 1'b1;
            end else if (busy) begin
                bcd <= bcd_step(bcd, sr[31]);
                sr  <= {sr[30:0], 1'b0};
                cnt <= cnt - 6'd1;
                if (cnt == 6'd1) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/wb_disp_sched.sv
// wb_disp_sched: buffers register writebacks and schedules them onto the
// seven-segment readout as sign + 3 BCD digits, one entry per hold period.
// Ports: clk, rst (async active-low), bus (wb_disp_sched_if.slave): writeback
// input, step_req, disp_* display fields, fifo_full, drop_cnt.
// Build option: WB_DISP_STEP_EN replaces the hold timer with step_req advance.
module wb_disp_sched
    import wb_disp_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int HOLD_CYCLES = 50000000,
    parameter int DROP_W      = 8
) (
    input logic            clk,
    input logic            rst,
    wb_disp_sched_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    entry_t           mem [FIFO_DEPTH];
    entry_t           head;
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    count, count_next;
    state_t           state;
    logic [7:0]       cur_pc;
    logic [4:0]       cur_rd;
    logic             cur_neg;
    logic             push, pop, accept, leave;
    logic [31:0]      mag;
    logic             conv_busy, conv_done;
    logic [BCD_W-1:0] bcd;

    always_comb begin
        head       = mem[rd_ptr];
        push       = bus.wb_valid && bus.wb_rd != 5'd0;
        pop        = (state == IDLE || leave) && count != '0;
        // A pop on the same edge frees the slot, so a full FIFO still accepts.
        accept     = push && (count != CW'(FIFO_DEPTH) || pop);
        count_next = count + CW'(accept) - CW'(pop);
        mag        = head.val[31] ? -head.val : head.val;
    end

`ifdef WB_DISP_STEP_EN
    always_comb leave = state == SHOW && bus.step_req;
`else
    logic [31:0] timer;

    always_comb leave = state == SHOW && timer == '0;

    always_ff @(posedge clk or negedge rst)
        if (!rst) timer <= '0;
        else timer <= state == DONE ? 32'(HOLD_CYCLES - 1) :
                      (state == SHOW && timer != '0) ? timer - 32'd1 : timer;
`endif

    always_ff @(posedge clk)
        if (accept) mem[wr_ptr] <= {bus.wb_pc, bus.wb_rd, bus.wb_val};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            state          <= IDLE;
            cur_pc         <= '0;
            cur_rd         <= '0;
            cur_neg        <= 1'b0;
            bus.fifo_full  <= 1'b0;
            bus.drop_cnt   <= '0;
            bus.disp_valid <= 1'b0;
            bus.disp_pc    <= '0;
            bus.disp_rd    <= '0;
            bus.disp_neg   <= 1'b0;
            bus.disp_hund  <= '0;
            bus.disp_ten   <= '0;
            bus.disp_one   <= '0;
            bus.disp_ovf   <= 1'b0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count         <= count_next;
            bus.fifo_full <= count_next == CW'(FIFO_DEPTH);
            if (push && !accept && bus.drop_cnt != {DROP_W{1'b1}})
                bus.drop_cnt <= bus.drop_cnt + DROP_W'(1);
            if (pop) begin
                cur_pc  <= head.pc;
                cur_rd  <= head.rd;
                cur_neg <= head.val[31];
                state   <= CONV;
            end else if (state == CONV && conv_done && !conv_busy) begin
                state <= DONE;
            end else if (state == DONE) begin
                bus.disp_valid <= 1'b1;
                bus.disp_pc    <= cur_pc;
                bus.disp_rd    <= cur_rd;
                bus.disp_neg   <= cur_neg;
                bus.disp_hund  <= bcd[2*DIGIT_W +: DIGIT_W];
                bus.disp_ten   <= bcd[DIGIT_W +: DIGIT_W];
                bus.disp_one   <= bcd[0 +: DIGIT_W];
                bus.disp_ovf   <= |bcd[BCD_W-1:3*DIGIT_W];
                state          <= SHOW;
            end else if (leave) begin
                state <= IDLE;
            end
        end
    end

    bin2bcd_seq u_conv (
        .clk   (clk),
        .rst   (rst),
        .start (pop),
        .din   (mag),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (bcd)
    );
endmodule
